// File: rtl/tetris_pkg.sv
// Shared constants and types for the game's scoring and display blocks.
package tetris_pkg;

  localparam logic [7:0] SCORE_MAX_BCD = 8'h99;
  localparam logic [4:0] PENDING_MAX   = 5'd31;

  typedef enum logic {
    IDLE = 1'b0,
    ADD  = 1'b1
  } score_state_t;

  // Points awarded for a clear, indexed by the number of full rows (0..8).
  localparam logic [3:0] LINE_POINTS [0:8] = '{
    4'd0, 4'd1, 4'd3, 4'd5, 4'd8, 4'd8, 4'd8, 4'd8, 4'd8
  };

  // Segment patterns, a..g on [6:0], active-high.
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
  };

endpackage

// File: rtl/bcd_to_seg7.sv
// Single-digit BCD to 7-segment decoder; non-BCD codes blank the digit.
module bcd_to_seg7
  import tetris_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    seg = 7'b0000000;
    if (bcd <= 4'd9) seg = SEG_DIGIT[bcd];
  end

endmodule

// File: rtl/score_display.sv
// Converts line-clear events into points, steps a saturating BCD score one
// unit per cycle, and scans it onto a two-digit multiplexed 7-segment display.
module score_display
  import tetris_pkg::*;
#(
  parameter int SCAN_DIV = 25000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] remove_line,
  output logic [7:0] score_bcd,
  output logic       busy,
  output logic [6:0] seg,
  output logic       seg_COM
);

  localparam int SCAN_W = $clog2(SCAN_DIV);

  score_state_t      state, state_next;
  logic              prev_any;
  logic [4:0]        pending, pending_next;
  logic [SCAN_W-1:0] scan_cnt;

  logic              any_line, line_event;
  logic [3:0]        line_cnt, points;
  logic [5:0]        pending_sum;
  logic [7:0]        score_inc;
  logic [3:0]        digit;

  assign any_line   = |remove_line;
  assign line_event = any_line & ~prev_any;

  always_comb begin
    line_cnt = 4'd0;
    for (int i = 0; i < 8; i++) line_cnt = line_cnt + 4'(remove_line[i]);
  end

  assign points = line_event ? LINE_POINTS[line_cnt] : 4'd0;

  // Drain one point per cycle while new points from this edge merge in.
  always_comb begin
    pending_sum  = {1'b0, pending} - 6'(pending != 5'd0) + 6'(points);
    pending_next = (pending_sum > 6'(PENDING_MAX)) ? PENDING_MAX : pending_sum[4:0];
    state_next   = (pending_next != 5'd0) ? ADD : IDLE;
  end

  assign score_inc = (score_bcd[3:0] == 4'd9) ? {score_bcd[7:4] + 4'd1, 4'd0}
                                               : {score_bcd[7:4], score_bcd[3:0] + 4'd1};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      prev_any  <= 1'b0;
      pending   <= 5'd0;
      score_bcd <= 8'h00;
    end else begin
      state    <= state_next;
      prev_any <= any_line;
      pending  <= pending_next;
      if (state == ADD && score_bcd != SCORE_MAX_BCD) score_bcd <= score_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt <= '0;
      seg_COM  <= 1'b0;
    end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      seg_COM  <= ~seg_COM;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  assign busy  = (state == ADD);
  assign digit = seg_COM ? score_bcd[7:4] : score_bcd[3:0];

  bcd_to_seg7 u_seg7 (
    .bcd (digit),
    .seg (seg)
  );

endmodule
